// File: rtl/serial_deserializer.sv
// serial_deserializer: packs a registered 1-bit stream into WIDTH-bit words.
// A WIDTH-bit shift register fills under a valid/ready input handshake. Each
// completed word moves into a registered output with its own valid/ready
// handshake. When the output is occupied, a completed word parks in the shift
// register (STALL) and the input stops accepting bits until the output drains.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           din_valid,
  input  logic                           din,
  output logic                           din_ready,
  output logic [WIDTH-1:0]               dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [$clog2(WIDTH+1)-1:0]     bit_count
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  typedef enum logic {
    S_FILL  = 1'b0,  // 0..WIDTH-1 bits held
    S_STALL = 1'b1   // WIDTH bits held, output occupied
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic             accept;
  logic             drain;
  logic [WIDTH-1:0] shifted;

  // Input is refused while reset is held and while a completed word is parked.
  assign din_ready = reset && (state_q != S_STALL);

  // flush outranks a bit presented on the same edge, so that bit is dropped.
  assign accept = din_valid && din_ready && !flush;
  assign drain  = dout_valid_q && dout_ready;

  // Shift register contents with the incoming bit inserted at the entry end.
  assign shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]};

  // Next-state computation for the shift register, counter, FSM and output.
  always_comb begin
    // NOTE: every _d is given its hold value first so no path can leave it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    // A drain frees the output; a load later in this block re-occupies it.
    if (drain) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      S_FILL: begin
        if (flush) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LAST_IDX) begin
            if (!dout_valid_q || dout_ready) begin
              // Output free (or freeing this edge): word goes straight out.
              dout_d       = shifted;
              dout_valid_d = 1'b1;
              sr_d         = '0;
              cnt_d        = '0;
            end else begin
              // Output busy: park the full word and block further input.
              sr_d    = shifted;
              cnt_d   = FULL_CNT;
              state_d = S_STALL;
            end
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_STALL: begin
        if (flush) begin
          // Parked word is dropped; the output word is untouched.
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_FILL;
        end else if (dout_ready) begin
          // Output drains this edge, so the parked word takes its place.
          dout_d       = sr_q;
          dout_valid_d = 1'b1;
          sr_d         = '0;
          cnt_d        = '0;
          state_d      = S_FILL;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      sr_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign bit_count  = cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Testbench for serial_deserializer. Two instances (MSB-first and LSB-first)
// share every input. Expected words are queued when a word is sent, and a
// monitor pops and compares them whenever an output word is consumed.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             dout_ready = 1'b0;

  logic             din_ready_m, din_ready_l;
  logic [WIDTH-1:0] dout_m, dout_l;
  logic             dout_valid_m, dout_valid_l;
  logic [CW-1:0]    bit_count_m, bit_count_l;

  int n_vec  = 0;
  int n_miss = 0;

  logic [WIDTH-1:0] exp_m_q[$];
  logic [WIDTH-1:0] exp_l_q[$];

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .flush(flush),
    .din_valid(din_valid), .din(din), .din_ready(din_ready_m),
    .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .bit_count(bit_count_m)
  );

  serial_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .flush(flush),
    .din_valid(din_valid), .din(din), .din_ready(din_ready_l),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .bit_count(bit_count_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one bit and hold it until accepted; reports cycles spent waiting.
  task automatic send_bit(input logic b, output int waits);
    waits     = 0;
    din_valid = 1'b1;
    din       = b;
    while (1) begin
      @(negedge clk);
      if (din_ready_m) begin
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      if (waits > 100) begin
        check("accept_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    din_valid = 1'b0;
  endtask

  // Send an 8-bit pattern first-bit = w[7]; optionally queue expected words.
  task automatic send_word(input logic [7:0] w, input logic [7:0] wl, input bit push);
    int wt;
    if (push) begin
      exp_m_q.push_back(w);
      exp_l_q.push_back(wl);
    end
    for (int i = 7; i >= 0; i--) send_bit(w[i], wt);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare consumed words against the queues and enforce stable hold.
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_dout = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_dout", 32'(dout_m), 32'(prev_dout));
        check("hold_valid", 32'(dout_valid_m), 32'd1);
      end
      if (dout_valid_m && dout_ready) begin
        if (exp_m_q.size() == 0) check("msb_unexpected_word", 32'(dout_m), 32'hxxxx_xxxx);
        else check("msb_word", 32'(dout_m), 32'(exp_m_q.pop_front()));
      end
      if (dout_valid_l && dout_ready) begin
        if (exp_l_q.size() == 0) check("lsb_unexpected_word", 32'(dout_l), 32'hxxxx_xxxx);
        else check("lsb_word", 32'(dout_l), 32'(exp_l_q.pop_front()));
      end
      prev_hold = dout_valid_m && !dout_ready;
      prev_dout = dout_m;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    int wt;

    // Reset state
    #3;
    check("rst_dout_valid", 32'(dout_valid_m), 32'd0);
    check("rst_din_ready", 32'(din_ready_m), 32'd0);
    check("rst_bit_count", 32'(bit_count_m), 32'd0);
    check("rst_dout", 32'(dout_m), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    check("post_rst_din_ready", 32'(din_ready_m), 32'd1);

    // 1+2: stream B2 back-to-back, output always ready (LSB-first sees 4D)
    dout_ready = 1'b1;
    w = 8'hB2;
    exp_m_q.push_back(8'hB2);
    exp_l_q.push_back(8'h4D);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], wt);
      if (i > 0) check("t1_bit_count", 32'(bit_count_m), 32'(8 - i));
    end
    check("t1_count_wrap", 32'(bit_count_m), 32'd0);
    check("t1_valid", 32'(dout_valid_m), 32'd1);
    check("t1_dout", 32'(dout_m), 32'hB2);
    check("t1_dout_lsb", 32'(dout_l), 32'h4D);
    idle(1);
    check("t1_valid_one_cycle", 32'(dout_valid_m), 32'd0);

    // 3: output blocked, B2 loads, 5A stalls; then drain both
    dout_ready = 1'b0;
    send_word(8'hB2, 8'h4D, 1'b1);
    send_word(8'h5A, 8'h5A, 1'b1);
    check("t3_din_ready_stall", 32'(din_ready_m), 32'd0);
    check("t3_bit_count_full", 32'(bit_count_m), 32'd8);
    check("t3_dout_held", 32'(dout_m), 32'hB2);
    idle(3);
    check("t3_dout_still", 32'(dout_m), 32'hB2);
    dout_ready = 1'b1;
    idle(1);
    check("t3_dout_second", 32'(dout_m), 32'h5A);
    check("t3_valid_second", 32'(dout_valid_m), 32'd1);
    check("t3_count_after_move", 32'(bit_count_m), 32'd0);
    idle(1);
    check("t3_valid_drained", 32'(dout_valid_m), 32'd0);
    check("t3_din_ready_back", 32'(din_ready_m), 32'd1);

    // 4: last bit of 3C lands on the edge that drains held B2
    dout_ready = 1'b0;
    send_word(8'hB2, 8'h4D, 1'b1);
    w = 8'h3C;
    exp_m_q.push_back(8'h3C);
    exp_l_q.push_back(8'h3C);
    for (int i = 7; i >= 1; i--) begin
      send_bit(w[i], wt);
      check("t4_no_wait", 32'(wt), 32'd0);
    end
    dout_ready = 1'b1;
    send_bit(w[0], wt);
    check("t4_no_wait_last", 32'(wt), 32'd0);
    check("t4_dout", 32'(dout_m), 32'h3C);
    check("t4_valid", 32'(dout_valid_m), 32'd1);
    check("t4_din_ready", 32'(din_ready_m), 32'd1);
    check("t4_bit_count", 32'(bit_count_m), 32'd0);
    idle(1);
    check("t4_drained", 32'(dout_valid_m), 32'd0);

    // 5: asynchronous reset mid-word, then A5 with no residue
    send_bit(1'b1, wt);
    send_bit(1'b0, wt);
    send_bit(1'b1, wt);
    check("t5_partial_count", 32'(bit_count_m), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(dout_valid_m), 32'd0);
    check("t5_rst_dout", 32'(dout_m), 32'd0);
    check("t5_rst_count", 32'(bit_count_m), 32'd0);
    check("t5_rst_din_ready", 32'(din_ready_m), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    send_word(8'hA5, 8'hA5, 1'b1);
    check("t5_dout", 32'(dout_m), 32'hA5);
    idle(1);

    // 6: flush after 5 bits, with a bit offered on the flush edge
    w = 8'hC8;
    for (int i = 7; i >= 3; i--) send_bit(w[i], wt);
    check("t6_count5", 32'(bit_count_m), 32'd5);
    flush = 1'b1; din_valid = 1'b1; din = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; din_valid = 1'b0;
    check("t6_flush_count", 32'(bit_count_m), 32'd0);
    check("t6_flush_dout", 32'(dout_m), 32'hA5);
    check("t6_flush_valid", 32'(dout_valid_m), 32'd0);
    send_word(8'hC3, 8'hC3, 1'b1);
    check("t6_dout", 32'(dout_m), 32'hC3);
    idle(1);

    // 7: flush in STALL drops the parked word while the output drains
    dout_ready = 1'b0;
    send_word(8'h11, 8'h88, 1'b1);
    send_word(8'hFF, 8'hFF, 1'b0);
    check("t7_stall", 32'(din_ready_m), 32'd0);
    flush = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t7_valid", 32'(dout_valid_m), 32'd0);
    check("t7_count", 32'(bit_count_m), 32'd0);
    check("t7_din_ready", 32'(din_ready_m), 32'd1);
    check("t7_dout_kept", 32'(dout_m), 32'h11);

    idle(3);
    check("queue_msb_empty", 32'(exp_m_q.size()), 32'd0);
    check("queue_lsb_empty", 32'(exp_l_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
